core_sysinfo: RTL

Parametrised system-information slave on the Avalon-MM control bus, replacing the single-word sysid. Returns build constants (system ID, build timestamp, capability word, up to 8 user words), a 64-bit free-running uptime counter with atomic low/high readout, and one read/write scratch register. Reads have a fixed one-cycle registered latency. Software uses it for image identification, elapsed-time measurement and bus sanity checks.

---
 rtl/core_sysinfo_if.sv | 39 +++
 rtl/core_sysinfo.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/core_sysinfo_if.sv
// core_sysinfo_if: Avalon-MM style control-bus bundle for the system-information slave.
//
// Signals:
//   address        word address (16 words)
//   read           read strobe, one cycle per transfer
//   write          write strobe, one cycle per transfer
//   writedata      write data
//   readdata       registered read data, driven by the slave
//   readdatavalid  one-cycle pulse one edge after an accepted read
//
// Modports:
//   master  drives strobes/address/writedata, receives read data
//   slave   receives strobes/address/writedata, drives read data
interface core_sysinfo_if;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata,
    output readdatavalid
  );
endinterface

// File: rtl/core_sysinfo.sv
// core_sysinfo: system-information slave. Serves build constants, a 64-bit free-running
// uptime counter with atomic low/high readout through a shadow register, and one scratch word.
// Reads complete with a fixed one-cycle registered latency; there is no waitrequest.
//
// Ports:
//   clk_i   system clock, all logic on the rising edge
//   rst_ni  asynchronous active-low reset (release synchronised externally)
//   bus     core_sysinfo_if slave modport (address/read/write/writedata in,
//           readdata/readdatavalid out)
//
// Word map (read):
//   0x0 SYSTEM_ID, 0x1 TIMESTAMP, 0x2 uptime[31:0] (also latches uptime[63:32] into shadow),
//   0x3 shadow, 0x4 scratch, 0x5 caps, 0x6-0x7 zero, 0x8+i user word i (zero if i >= NUM_USER)
// Word map (write):
//   0x2 clears the uptime counter, 0x4 loads scratch, all others ignored
module core_sysinfo #(
  parameter logic [31:0]  SYSTEM_ID   = 32'h0000_0000,
  parameter logic [31:0]  TIMESTAMP   = 32'd1450868559,
  parameter int unsigned  NUM_USER    = 2,
  parameter logic [255:0] USER_WORDS  = 256'h0,
  parameter logic [31:0]  SCRATCH_RST = 32'hDEAD_BEEF
) (
  input logic           clk_i,
  input logic           rst_ni,
  core_sysinfo_if.slave bus
);

  localparam logic [3:0] AddrSysId    = 4'h0;
  localparam logic [3:0] AddrTstamp   = 4'h1;
  localparam logic [3:0] AddrUptimeLo = 4'h2;
  localparam logic [3:0] AddrUptimeHi = 4'h3;
  localparam logic [3:0] AddrScratch  = 4'h4;
  localparam logic [3:0] AddrCaps     = 4'h5;

  localparam logic [3:0]  NumUserW = NUM_USER[3:0];
  // Capability word: version 1 in the upper half, user-word count in the low nibble.
  localparam logic [31:0] CapsWord = {16'h0001, 8'h00, 4'h0, NumUserW};

  // ---------------------------------------------------------------------------
  // Configuration check
  // ---------------------------------------------------------------------------
  if (NUM_USER > 8) begin : g_cfg_err
    always_ff @(posedge clk_i) begin
      $error("core_sysinfo: NUM_USER=%0d exceeds the maximum of 8", NUM_USER);
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [63:0] uptime_q, uptime_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  // ---------------------------------------------------------------------------
  // Strobe decode
  // ---------------------------------------------------------------------------
  logic rd_accept;
  logic uptime_clr;
  logic scratch_we;

  always_comb begin
    // A simultaneous write wins; the read is dropped entirely.
    rd_accept  = bus.read & ~bus.write;
    uptime_clr = bus.write & (bus.address == AddrUptimeLo);
    scratch_we = bus.write & (bus.address == AddrScratch);
  end

  // ---------------------------------------------------------------------------
  // User word select
  // ---------------------------------------------------------------------------
  logic [2:0]  user_idx;
  logic [31:0] user_word;

  always_comb begin
    user_idx  = bus.address[2:0];
    user_word = '0;
    if (32'(user_idx) < NUM_USER) begin
      user_word = USER_WORDS[{user_idx, 5'd0} +: 32];
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (bus.address[3]) begin
      rd_word = user_word;
    end else begin
      unique case (bus.address[2:0])
        AddrSysId[2:0]:    rd_word = SYSTEM_ID;
        AddrTstamp[2:0]:   rd_word = TIMESTAMP;
        AddrUptimeLo[2:0]: rd_word = uptime_q[31:0];
        AddrUptimeHi[2:0]: rd_word = shadow_q;
        AddrScratch[2:0]:  rd_word = scratch_q;
        AddrCaps[2:0]:     rd_word = CapsWord;
        3'd6:              rd_word = '0;
        3'd7:              rd_word = '0;
        default:           rd_word = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // Free-running; a clear lands on this edge so the next cycle reads 0.
    uptime_d  = uptime_clr ? 64'd0 : uptime_q + 64'd1;
    // Shadow is only loaded by a low-word read, so the high word pairs with the
    // low word software just read, regardless of any later carry or clear.
    shadow_d  = (rd_accept && bus.address == AddrUptimeLo) ? uptime_q[63:32] : shadow_q;
    scratch_d = scratch_we ? bus.writedata : scratch_q;
    // Read data holds its last value between reads.
    rdata_d   = rd_accept ? rd_word : rdata_q;
    rvalid_d  = rd_accept;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      uptime_q  <= '0;
      shadow_q  <= '0;
      scratch_q <= SCRATCH_RST;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      uptime_q  <= uptime_d;
      shadow_q  <= shadow_d;
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rvalid_q;

endmodule
